timer_seq_ctrl: RTL

- Sequencing controller for the 16-bit up/down/load counter.
- Drives the counter's D/ld/up/dw pins and watches its Q/UTC/DTC outputs.
- Runs countdown-timer or up-count-to-limit sessions gated by an external tick enable, with start/pause/resume/clear control and a one-cycle done pulse.
- Sits between the top-level button/FSM logic and the counter instance.

---
 rtl/timer_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/timer_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timer_seq_ctrl
//  Purpose  : Sequencing controller for a WIDTH-bit up/down/load counter.
//             Runs countdown or count-up-to-limit sessions paced by an
//             external tick, with start/pause/resume/clear and a done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module timer_seq_ctrl #(
  parameter int WIDTH       = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             dir_up,
  input  logic [WIDTH-1:0] preset,
  input  logic             tick,
  input  logic [WIDTH-1:0] cnt_Q,
  input  logic             cnt_UTC,
  input  logic             cnt_DTC,
  output logic [WIDTH-1:0] cnt_D,
  output logic             cnt_ld,
  output logic             cnt_up,
  output logic             cnt_dw,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] preset_r;
  logic             dir_r;
  logic             term;
  logic             latch_cfg;
  logic             unused_status;

  // The all-ones flag is status only; terminal detection uses Q or DTC.
  assign unused_status = cnt_UTC;

  // Up sessions end when Q reaches the limit, down sessions when Q hits zero.
  assign term = dir_r ? (cnt_Q == preset_r) : cnt_DTC;

  // A new session (from IDLE or DONE) captures preset and direction.
  assign latch_cfg = start & ~clear & ((state_r == S_IDLE) | (state_r == S_DONE));

  assign busy  = (state_r == S_LOAD) | (state_r == S_RUN);
  assign state = state_r;

  // State, session configuration and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      preset_r <= '0;
      dir_r    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r <= state_nx;
      done    <= ~clear & (state_r == S_RUN) & term;
      if (latch_cfg) begin
        preset_r <= preset;
        dir_r    <= dir_up;
      end
    end
  end

  // Next-state and counter-pin decode; clear overrides every transition.
  always_comb begin
    state_nx = state_r;
    cnt_D    = '0;
    cnt_ld   = 1'b0;
    cnt_up   = 1'b0;
    cnt_dw   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_ld = 1'b1;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        cnt_ld   = 1'b1;
        cnt_D    = dir_r ? '0 : preset_r;
        state_nx = S_RUN;
      end
      S_RUN: begin
        // Enables are masked at terminal count so the counter never wraps.
        cnt_up = tick & dir_r & ~term;
        cnt_dw = tick & ~dir_r & ~term;
        if (term)      state_nx = AUTO_RELOAD ? S_LOAD : S_DONE;
        else if (stop) state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        if (start) state_nx = S_RUN;
      end
      S_DONE: begin
        if (start) state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
    if (clear) state_nx = S_IDLE;
  end

endmodule
`default_nettype wire
